// File: rtl/bcd_pkg.sv
// Shared types and constants for the 4-digit BCD to binary converter.
// Used by bcd2bin_1dig and bcd2bin_4dig_matrix via import bcd_pkg::*.
package bcd_pkg;

    localparam int BCD_DIG_W = 4;
    localparam int NDIG      = 4;
    localparam int BIN_W     = 14;

    // Largest decimal value four digits can hold (9999)
    localparam logic [15:0] MAX_DEC = 16'h270F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef logic [BCD_DIG_W-1:0] digit_t;

    // A nibble above 9 is not a legal BCD digit
    function automatic logic digit_invalid(input digit_t d);
        return (d > 4'd9);
    endfunction

endpackage

// File: rtl/bcd2bin_1dig.sv
// One BCD digit cell of the reverse double-dabble chain.
// On load the digit is captured; on shift the bit from the digit above
// enters at bit 3, bit 0 leaves on d_out, and the shifted value is
// corrected by -3 when it is 8 or more.
module bcd2bin_1dig
    import bcd_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   shift,
    input  digit_t load_val,
    input  logic   d_in,
    output logic   d_out,
    output digit_t q
);

    digit_t digit_q;
    digit_t digit_d;
    digit_t shifted;

    // Next digit value: load wins over shift, shift applies the -3 correction
    always_comb begin
        shifted = {d_in, digit_q[BCD_DIG_W-1:1]};
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (shift) begin
            digit_d = (shifted >= 4'd8) ? (shifted - 4'd3) : shifted;
        end
    end

    // Digit register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign d_out = digit_q[0];
    assign q     = digit_q;

endmodule

// File: rtl/bcd2bin_4dig_matrix.sv
// Sequential 4-digit packed-BCD to 16-bit binary converter using reverse
// double-dabble: 14 right shifts, one per clock, with start/busy/done.
// Optional digit checker enabled by defining BCD2BIN_DIGIT_CHECK_EN:
// an illegal digit (A-F) raises err at done and forces bin_out to zero.
module bcd2bin_4dig_matrix #(
    parameter int NDIG  = 4,
    parameter int OUT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NDIG*4-1:0]  bcd_in,
    output logic               busy,
    output logic               done,
    output logic [OUT_W-1:0]   bin_out,
    output logic               err
);

    import bcd_pkg::*;

    if (NDIG != 4) begin : g_bad_ndig
        $error("bcd2bin_4dig_matrix: NDIG must be 4");
    end
    if (OUT_W < BIN_W) begin : g_bad_out_w
        $error("bcd2bin_4dig_matrix: OUT_W must be at least 14");
    end

    state_t             state_q;
    logic [3:0]         iter_q;
    logic [BIN_W-1:0]   binField_q;
    logic [BIN_W-1:0]   binField_d;
    logic               busy_q;
    logic               done_q;
    logic [OUT_W-1:0]   binOut_q;
    logic [OUT_W-1:0]   finalOut;

    logic               loadDigits;
    logic               shiftDigits;
    logic [NDIG:0]      chain;
    digit_t             digitQ [NDIG];

    assign loadDigits  = (state_q == IDLE) && start;
    assign shiftDigits = (state_q == SHIFT);

    // Nothing enters above the most significant digit
    assign chain[NDIG] = 1'b0;

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        bcd2bin_1dig u_dig (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (loadDigits),
            .shift    (shiftDigits),
            .load_val (bcd_in[i*BCD_DIG_W +: BCD_DIG_W]),
            .d_in     (chain[i+1]),
            .d_out    (chain[i]),
            .q        (digitQ[i])
        );
    end

    // Binary field: cleared on acceptance, takes the ones digit's LSB at the top on each shift
    always_comb begin
        binField_d = binField_q;
        if (loadDigits) begin
            binField_d = '0;
        end else if (shiftDigits) begin
            binField_d = {chain[0], binField_q[BIN_W-1:1]};
        end
    end

    // Control FSM with registered busy/done/bin_out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            iter_q     <= '0;
            binField_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            binOut_q   <= '0;
        end else begin
            binField_q <= binField_d;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SHIFT;
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    iter_q <= iter_q + 4'd1;
                    if (iter_q == 4'(BIN_W - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    done_q   <= 1'b1;
                    binOut_q <= finalOut;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic errPend_q;
    logic err_q;
    logic anyInvalid;

    // Digits still hold the captured value during the first shift cycle
    always_comb begin
        anyInvalid = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            anyInvalid = anyInvalid | digit_invalid(digitQ[i]);
        end
    end

    // Latch the digit check for this conversion and publish it at done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            errPend_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                errPend_q <= 1'b0;
            end else if (state_q == SHIFT && iter_q == 4'd0) begin
                errPend_q <= anyInvalid;
            end
            if (state_q == DONE) begin
                err_q <= errPend_q;
            end
        end
    end

    assign finalOut = errPend_q ? '0 : OUT_W'(binField_q);
    assign err      = err_q;
`else
    logic unused_digits;

    assign unused_digits = ^{digitQ[0], digitQ[1], digitQ[2], digitQ[3]};
    assign finalOut      = OUT_W'(binField_q);
    assign err           = 1'b0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = binOut_q;

endmodule

// File: tb/tb_bcd2bin_4dig_matrix.sv
// Self-checking bench for bcd2bin_4dig_matrix: directed cases plus random
// valid BCD values compared against a decimal-arithmetic reference model.
module tb_bcd2bin_4dig_matrix;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [15:0] bin_out;
    logic        err;

    int checkCount = 0;
    int errorCount = 0;

    bcd2bin_4dig_matrix #(
        .NDIG  (4),
        .OUT_W (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Reference model: decimal value of four packed BCD digits
    function automatic logic [15:0] refBin(input logic [15:0] bcd);
        int v;
        v = int'(bcd[15:12]) * 1000 + int'(bcd[11:8]) * 100
          + int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
        return 16'(v);
    endfunction

    // One comparison: count it, and on mismatch count and report the failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present a start pulse; called at a negedge so the next posedge accepts it
    task automatic applyStimulus(input logic [15:0] val);
        bcd_in = val;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Full conversion: start, wait (bounded) for done, check latency, busy span, result
    task automatic runConv(input logic [15:0] val, input logic [15:0] expBin,
                           input logic expErr, input bit pokeStart, input string tag);
        int cyc;
        int busyCnt;
        bit gotDone;
        applyStimulus(val);
        bcd_in  = ~val;
        cyc     = 0;
        busyCnt = 0;
        gotDone = 1'b0;
        while (!gotDone && cyc < 40) begin
            if (pokeStart) start = (cyc == 2 || cyc == 14);
            if (done) begin
                gotDone = 1'b1;
            end else begin
                if (busy) busyCnt++;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        checkOutput({tag, "_latency"}, cyc, 15);
        checkOutput({tag, "_busyCycles"}, busyCnt, 14);
        checkOutput({tag, "_busyAtDone"}, busy, 0);
        checkOutput({tag, "_binOut"}, bin_out, expBin);
        checkOutput({tag, "_err"}, err, expErr);
    endtask

    // Directed and random sequence
    initial begin
        int doneCnt;
        int busyCnt;
        logic [15:0] val;
        logic [3:0]  dig [4];

        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_binOut", bin_out, 0);
        checkOutput("reset_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Max value, then back-to-back starts at the earliest legal cycle
        runConv(16'h9999, 16'h270F, 1'b0, 1'b0, "max9999");
        runConv(16'h1234, 16'h04D2, 1'b0, 1'b0, "b2b1234");
        runConv(16'h0000, 16'h0000, 1'b0, 1'b0, "b2b0000");
        runConv(16'h0001, 16'h0001, 1'b0, 1'b0, "b2b0001");

        // Starts during SHIFT and DONE are ignored
        runConv(16'h0500, 16'h01F4, 1'b0, 1'b1, "ignore0500");
        doneCnt = 0;
        busyCnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) doneCnt++;
            if (busy) busyCnt++;
        end
        checkOutput("ignore_extraDone", doneCnt, 0);
        checkOutput("ignore_extraBusy", busyCnt, 0);
        checkOutput("ignore_heldBinOut", bin_out, 16'h01F4);
        runConv(16'h0777, 16'h0309, 1'b0, 1'b0, "afterIgnore0777");

        // Reset in the middle of a conversion aborts it
        applyStimulus(16'h1234);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_binOut", bin_out, 0);
        rst_n = 1'b1;
        doneCnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("abort_noDone", doneCnt, 0);
        runConv(16'h0042, 16'h002A, 1'b0, 1'b0, "afterAbort0042");

        // Random valid BCD values against the decimal model
        for (int n = 0; n < 300; n++) begin
            for (int d = 0; d < 4; d++) dig[d] = 4'($urandom_range(0, 9));
            val = {dig[3], dig[2], dig[1], dig[0]};
            runConv(val, refBin(val), 1'b0, 1'b0, "rand");
        end

`ifdef BCD2BIN_DIGIT_CHECK_EN
        // Illegal digit flags err and zeroes the result; a clean value clears err
        runConv(16'h12A4, 16'h0000, 1'b1, 1'b0, "badDigit12A4");
        runConv(16'h0099, 16'h0063, 1'b0, 1'b0, "good0099");
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
